// File: rtl/pte_cache_ctrl.sv
// Fully associative PTE cache for the page-table walker: level-gated lookups with a
// one-cycle registered response, fills with duplicate-tag update and round-robin replacement.
module pte_cache_ctrl #(
    parameter int ENTRIES       = 8,
    parameter int PADDR_W       = 50,
    parameter int TAG_W         = 32,
    parameter int DATA_W        = 64,
    parameter int LEVEL_W       = 2,
    parameter int MAX_HIT_LEVEL = 2,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               lookup_valid,
    output logic               lookup_ready,
    input  logic [PADDR_W-1:0] lookup_addr,
    input  logic [LEVEL_W-1:0] lookup_level,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [ENTRIES-1:0] resp_way,
    output logic [DATA_W-1:0]  resp_data,
    input  logic               fill_valid,
    input  logic [PADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0]  fill_data,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [LEVEL_W:0] MAX_LVL = (LEVEL_W+1)'(MAX_HIT_LEVEL);

    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_reg  [ENTRIES];
    logic [DATA_W-1:0]  data_reg [ENTRIES];
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   ptr_next;

    logic               resp_valid_reg;
    logic               resp_hit_reg;
    logic [ENTRIES-1:0] resp_way_reg;
    logic [DATA_W-1:0]  resp_data_reg;
    logic [CNT_W-1:0]   hit_cnt_reg;
    logic [CNT_W-1:0]   miss_cnt_reg;

    logic               lookup_upper_ok;
    logic               fill_upper_ok;
    logic [ENTRIES-1:0] lookup_match;
    logic [ENTRIES-1:0] fill_match;
    logic [DATA_W-1:0]  hit_data;
    logic [IDX_W-1:0]   fill_idx;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_en;
    logic               accept;
    logic               hit;

    // Addresses with bits above the tag can never be cached.
    generate
        if (PADDR_W > TAG_W) begin : g_upper
            assign lookup_upper_ok = (lookup_addr[PADDR_W-1:TAG_W] == '0);
            assign fill_upper_ok   = (fill_addr[PADDR_W-1:TAG_W] == '0);
        end else begin : g_no_upper
            assign lookup_upper_ok = 1'b1;
            assign fill_upper_ok   = 1'b1;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign lookup_match[gi] = valid_reg[gi] && lookup_upper_ok &&
                                      (tag_reg[gi] == lookup_addr[TAG_W-1:0]);
            assign fill_match[gi]   = valid_reg[gi] && (tag_reg[gi] == fill_addr[TAG_W-1:0]);
        end
    endgenerate

    assign lookup_ready = !rst && !flush;
    assign accept       = lookup_valid && lookup_ready;
    assign hit          = (|lookup_match) && ({1'b0, lookup_level} < MAX_LVL);

    // Match vectors are at most one-hot, so an OR of masked data is a clean mux.
    always_comb begin
        hit_data = '0;
        fill_idx = '0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lookup_match[i]) hit_data = hit_data | data_reg[i];
            if (fill_match[i])   fill_idx = IDX_W'(i);
            if (!valid_reg[i])   free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = ptr_reg;
        ptr_next = ptr_reg;
        if (fill_valid && fill_upper_ok && !flush) begin
            wr_en = 1'b1;
            if (|fill_match) begin
                wr_idx = fill_idx;
            end else if (!(&valid_reg)) begin
                wr_idx = free_idx;
            end else begin
                wr_idx   = ptr_reg;
                ptr_next = ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            if (wr_en) valid_reg[wr_idx] <= 1'b1;
            ptr_reg <= ptr_next;
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_reg[wr_idx]  <= fill_addr[TAG_W-1:0];
            data_reg[wr_idx] <= fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_hit_reg   <= 1'b0;
            resp_way_reg   <= '0;
            resp_data_reg  <= '0;
        end else begin
            resp_valid_reg <= accept;
            resp_hit_reg   <= accept && hit;
            resp_way_reg   <= (accept && hit) ? lookup_match : '0;
            resp_data_reg  <= (accept && hit) ? hit_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (resp_valid_reg) begin
            if (resp_hit_reg) begin
                if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + 1'b1;
            end else begin
                if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + 1'b1;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_hit   = resp_hit_reg;
    assign resp_way   = resp_way_reg;
    assign resp_data  = resp_data_reg;
    assign hit_cnt    = hit_cnt_reg;
    assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_pte_cache_ctrl.sv
// Directed bench for pte_cache_ctrl: expected responses are queued with their due cycle
// and compared by a negedge monitor; counters are checked against a saturating model.
module tb_pte_cache_ctrl;

    localparam int ENTRIES = 8;
    localparam int PADDR_W = 50;
    localparam int DATA_W  = 64;
    localparam int LEVEL_W = 2;
    localparam int CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               lookup_valid;
    logic               lookup_ready;
    logic [PADDR_W-1:0] lookup_addr;
    logic [LEVEL_W-1:0] lookup_level;
    logic               resp_valid;
    logic               resp_hit;
    logic [ENTRIES-1:0] resp_way;
    logic [DATA_W-1:0]  resp_data;
    logic               fill_valid;
    logic [PADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0]  fill_data;
    logic [CNT_W-1:0]   hit_cnt;
    logic [CNT_W-1:0]   miss_cnt;

    pte_cache_ctrl #(
        .ENTRIES(ENTRIES), .PADDR_W(PADDR_W), .TAG_W(32), .DATA_W(DATA_W),
        .LEVEL_W(LEVEL_W), .MAX_HIT_LEVEL(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
        .lookup_addr(lookup_addr), .lookup_level(lookup_level),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_data(resp_data),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        int                 due;
        logic               hit;
        logic [ENTRIES-1:0] way;
        logic [DATA_W-1:0]  data;
    } resp_t;

    resp_t            exp_q[$];
    int               cyc = 0;
    int               n_assert = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] exp_hits = '0;
    logic [CNT_W-1:0] exp_misses = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: resp_valid must appear exactly in the cycles the queue says it is due.
    always @(negedge clk) begin
        logic  due_now;
        resp_t e;
        due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("resp_valid", {63'b0, resp_valid}, {63'b0, due_now});
        if (due_now) begin
            e = exp_q.pop_front();
            check("resp_hit", {63'b0, resp_hit}, {63'b0, e.hit});
            check("resp_way", {56'b0, resp_way}, {56'b0, e.way});
            check("resp_data", resp_data, e.data);
            $display("resp @%0d hit=%0b way=%02h data=%0h", cyc, resp_hit, resp_way, resp_data);
        end
    end

    task automatic push(input bit eh, input logic [ENTRIES-1:0] ew, input logic [DATA_W-1:0] ed);
        resp_t e;
        e.due  = cyc + 1;
        e.hit  = eh;
        e.way  = ew;
        e.data = ed;
        exp_q.push_back(e);
        if (eh) begin
            if (exp_hits != CNT_MAX) exp_hits++;
        end else begin
            if (exp_misses != CNT_MAX) exp_misses++;
        end
    endtask

    task automatic lookup(input logic [PADDR_W-1:0] a, input logic [LEVEL_W-1:0] lv,
                          input bit eh, input logic [ENTRIES-1:0] ew, input logic [DATA_W-1:0] ed);
        lookup_valid = 1'b1;
        lookup_addr  = a;
        lookup_level = lv;
        push(eh, ew, ed);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
    endtask

    task automatic fill(input logic [PADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        fill_valid = 1'b1;
        fill_addr  = a;
        fill_data  = d;
        @(posedge clk); #1;
        fill_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt();
        idle(2);
        check("hit_cnt", {56'b0, hit_cnt}, {56'b0, exp_hits});
        check("miss_cnt", {56'b0, miss_cnt}, {56'b0, exp_misses});
    endtask

    localparam logic [DATA_W-1:0] NODATA = '0;

    initial begin
        rst = 1'b1; flush = 1'b0;
        lookup_valid = 1'b0; lookup_addr = '0; lookup_level = '0;
        fill_valid = 1'b0; fill_addr = '0; fill_data = '0;
        idle(3);
        check("ready_in_rst", {63'b0, lookup_ready}, 64'd0);
        check("rst_resp_way", {56'b0, resp_way}, 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_hit_cnt", {56'b0, hit_cnt}, 64'd0);
        check("rst_miss_cnt", {56'b0, miss_cnt}, 64'd0);
        rst = 1'b0;
        #1 check("ready_after_rst", {63'b0, lookup_ready}, 64'd1);

        // 1: cold miss
        lookup(50'h100, 2'd0, 1'b0, 8'h00, NODATA);
        check_cnt();

        // 2: fill then level-gated lookups
        fill(50'h100, 64'hAAAA);
        lookup(50'h100, 2'd1, 1'b1, 8'h01, 64'hAAAA);
        lookup(50'h100, 2'd2, 1'b0, 8'h00, NODATA);
        lookup(50'h100, 2'd3, 1'b0, 8'h00, NODATA);
        lookup(50'h100, 2'd0, 1'b1, 8'h01, 64'hAAAA);

        // 3: fill 0..7 from empty, then round-robin replacement
        flush = 1'b1; idle(1); flush = 1'b0;
        for (int i = 0; i < 8; i++) fill(50'(i), 64'h1000 + 64'(i));
        fill(50'd8, 64'h1008);
        lookup(50'd0, 2'd0, 1'b0, 8'h00, NODATA);
        lookup(50'd8, 2'd0, 1'b1, 8'h01, 64'h1008);
        lookup(50'd5, 2'd1, 1'b1, 8'h20, 64'h1005);
        fill(50'd9, 64'h1009);
        lookup(50'd9, 2'd0, 1'b1, 8'h02, 64'h1009);
        lookup(50'd1, 2'd0, 1'b0, 8'h00, NODATA);
        check_cnt();

        // 4: duplicate-tag refill keeps the pointer; upper-bit fills are dropped
        fill(50'd3, 64'hBEEF);
        lookup(50'd3, 2'd0, 1'b1, 8'h08, 64'hBEEF);
        fill(50'd10, 64'h100A);
        lookup(50'd10, 2'd0, 1'b1, 8'h04, 64'h100A);
        lookup(50'd2, 2'd0, 1'b0, 8'h00, NODATA);
        fill(50'h1_0000_0004, 64'hDEAD);
        lookup(50'h1_0000_0004, 2'd0, 1'b0, 8'h00, NODATA);
        lookup(50'd4, 2'd0, 1'b1, 8'h10, 64'h1004);

        // 5: same-cycle fill and lookup sees old contents
        fill_valid = 1'b1; fill_addr = 50'h200; fill_data = 64'h2222;
        lookup(50'h200, 2'd0, 1'b0, 8'h00, NODATA);
        fill_valid = 1'b0;
        lookup(50'h200, 2'd0, 1'b1, 8'h08, 64'h2222);
        check_cnt();

        // 6: flush with a same-cycle fill and lookup
        flush = 1'b1;
        fill_valid = 1'b1; fill_addr = 50'h300; fill_data = 64'h3333;
        lookup_valid = 1'b1; lookup_addr = 50'h200; lookup_level = 2'd0;
        #1 check("ready_in_flush", {63'b0, lookup_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; fill_valid = 1'b0; lookup_valid = 1'b0;
        lookup(50'h200, 2'd0, 1'b0, 8'h00, NODATA);
        lookup(50'd8, 2'd0, 1'b0, 8'h00, NODATA);
        lookup(50'h300, 2'd0, 1'b0, 8'h00, NODATA);
        for (int i = 0; i < 8; i++) fill(50'h40 + 50'(i), 64'h3040 + 64'(i));
        fill(50'h48, 64'h3048);
        lookup(50'h48, 2'd0, 1'b1, 8'h01, 64'h3048);
        lookup(50'h40, 2'd0, 1'b0, 8'h00, NODATA);
        lookup(50'h41, 2'd1, 1'b1, 8'h02, 64'h3041);
        check_cnt();

        // hit counter saturation
        for (int i = 0; i < 270; i++) lookup(50'h48, 2'd0, 1'b1, 8'h01, 64'h3048);
        check_cnt();
        check("hit_cnt_sat", {56'b0, hit_cnt}, {56'b0, CNT_MAX});
        lookup(50'h48, 2'd1, 1'b1, 8'h01, 64'h3048);
        check_cnt();

        // reset (with flush) while a lookup is presented: nothing accepted, state cleared
        rst = 1'b1; flush = 1'b1;
        lookup_valid = 1'b1; lookup_addr = 50'h48; lookup_level = 2'd0;
        #1 check("ready_rst_flush", {63'b0, lookup_ready}, 64'd0);
        @(posedge clk); #1;
        lookup_valid = 1'b0; flush = 1'b0;
        idle(1);
        rst = 1'b0;
        exp_hits = '0; exp_misses = '0;
        check_cnt();
        lookup(50'h48, 2'd0, 1'b0, 8'h00, NODATA);
        check_cnt();
        idle(2);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
